// File: rtl/ysyx_24070016_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// fault-cause codes, the NOP instruction word and a PC alignment helper.
package ysyx_24070016_pkg;

    // Fetch FSM states: request, wait for response, hold for decoder, wait for commit.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_EXEC = 2'd3
    } fetch_state_e;

    // Fault cause reported alongside the instruction word.
    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_ACCESS   = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;

    // addi x0, x0, 0 -- substituted for the instruction whenever a fetch faults.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Default architectural reset PC.
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

    // A PC is fetchable only when it is word aligned.
    function automatic logic pc_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_24070016_Reg.sv
// Generic register with synchronous active-high reset and write enable.
// Used for the PC and the instruction holding registers of the fetch unit.
module ysyx_24070016_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    // Load the reset value on rst, otherwise capture din when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end else begin
            dout <= dout;
        end
    end

endmodule

// File: rtl/ysyx_24070016_ifu_fetch.sv
// Multi-cycle instruction fetch stage. Owns the architectural PC, issues a
// single word read per instruction, presents the result to the decoder with
// a valid/ready handshake and then waits for the commit stage to supply the
// next PC. Exactly one instruction is ever in flight.
module ysyx_24070016_ifu_fetch
    import ysyx_24070016_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    // instruction memory request channel
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    // instruction memory response channel
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    // decoder channel
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    // commit stage next-PC channel
    input  logic        npc_valid,
    input  logic [31:0] npc
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;

    logic [31:0] pc_r;
    logic        pc_wen_s;

    logic [31:0] inst_r;
    logic [31:0] inst_din_s;
    logic [1:0]  fault_r;
    logic [1:0]  fault_din_s;
    logic        hold_wen_s;

    logic        npc_aligned_s;

    assign npc_aligned_s = pc_aligned(npc);

    // State register; reset always returns the FSM to issuing a request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic for the fetch handshake sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_nxt_s = S_EXEC;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_EXEC: begin
                if (npc_valid) begin
                    // A misaligned target never reaches memory; it is reported
                    // directly to the decoder as a faulting NOP.
                    if (npc_aligned_s) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_HOLD;
                    end
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            default: begin
                state_nxt_s = S_REQ;
            end
        endcase
    end

    // Write enables and data for the PC and instruction holding registers.
    always_comb begin
        pc_wen_s    = 1'b0;
        hold_wen_s  = 1'b0;
        inst_din_s  = imem_resp_data;
        fault_din_s = FAULT_NONE;
        case (state_r)
            S_WAIT: begin
                // Responses are only meaningful here; elsewhere they are dropped.
                hold_wen_s = imem_resp_valid;
                if (imem_resp_err) begin
                    inst_din_s  = NOP_INST;
                    fault_din_s = FAULT_ACCESS;
                end else begin
                    inst_din_s  = imem_resp_data;
                    fault_din_s = FAULT_NONE;
                end
            end
            S_EXEC: begin
                pc_wen_s = npc_valid;
                if (npc_valid && !npc_aligned_s) begin
                    hold_wen_s  = 1'b1;
                    inst_din_s  = NOP_INST;
                    fault_din_s = FAULT_MISALIGN;
                end else begin
                    hold_wen_s  = 1'b0;
                    inst_din_s  = imem_resp_data;
                    fault_din_s = FAULT_NONE;
                end
            end
            default: begin
                pc_wen_s    = 1'b0;
                hold_wen_s  = 1'b0;
                inst_din_s  = imem_resp_data;
                fault_din_s = FAULT_NONE;
            end
        endcase
    end

    // Architectural PC; also serves as the PC reported with the instruction.
    ysyx_24070016_Reg #(
        .WIDTH     (32),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .din  (npc),
        .dout (pc_r),
        .wen  (pc_wen_s)
    );

    // Fetched (or substituted) instruction word held for the decoder.
    ysyx_24070016_Reg #(
        .WIDTH     (32),
        .RESET_VAL (32'h0000_0000)
    ) u_inst_reg (
        .clk  (clk),
        .rst  (rst),
        .din  (inst_din_s),
        .dout (inst_r),
        .wen  (hold_wen_s)
    );

    // Fault cause travelling with the held instruction.
    ysyx_24070016_Reg #(
        .WIDTH     (2),
        .RESET_VAL (FAULT_NONE)
    ) u_fault_reg (
        .clk  (clk),
        .rst  (rst),
        .din  (fault_din_s),
        .dout (fault_r),
        .wen  (hold_wen_s)
    );

    // Valids are state-decoded and forced low during the reset cycle so that
    // no handshake can complete while the stage is being reinitialised.
    assign imem_req_valid = (state_r == S_REQ)  && !rst;
    assign inst_valid     = (state_r == S_HOLD) && !rst;
    assign imem_req_addr  = pc_r;
    assign inst           = inst_r;
    assign inst_pc        = pc_r;
    assign inst_fault     = fault_r;

endmodule

// File: tb/tb_ysyx_24070016_ifu_fetch.sv
// Directed bench for the fetch stage: a table of commit/fetch vectors plus
// hand-written sequences for backpressure, idling, spurious responses and
// reset in the middle of an instruction. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_ysyx_24070016_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;
    logic        npc_valid;
    logic [31:0] npc;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] data;
        logic        err;
        logic [31:0] exp_inst;
        logic [1:0]  exp_fault;
        int          ready_dly;
        int          hold_dly;
    } vec_t;

    vec_t vecs [7];

    ysyx_24070016_ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault),
        .npc_valid       (npc_valid),
        .npc             (npc)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decoder side: instruction presented, held for hdly cycles, then accepted.
    task automatic hold(input logic [31:0] e_pc, input logic [31:0] e_inst,
                        input logic [1:0] e_fault, input int hdly);
        for (int i = 0; i <= hdly; i++) begin
            check("inst_valid_hold", {31'd0, inst_valid}, 32'd1);
            check("inst_hold", inst, e_inst);
            check("inst_pc_hold", inst_pc, e_pc);
            check("inst_fault_hold", {30'd0, inst_fault}, {30'd0, e_fault});
            check("no_req_in_hold", {31'd0, imem_req_valid}, 32'd0);
            if (i < hdly) begin
                inst_ready = 1'b0;
                @(negedge clk);
            end
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("inst_valid_exec", {31'd0, inst_valid}, 32'd0);
        check("req_valid_exec", {31'd0, imem_req_valid}, 32'd0);
    endtask

    // Full fetch starting with the DUT in S_REQ at the current falling edge.
    task automatic fetch(input logic [31:0] addr, input int rdly, input logic [31:0] data,
                         input logic err, input int hdly, input logic [31:0] e_inst,
                         input logic [1:0] e_fault);
        #1;
        check("req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req_addr", imem_req_addr, addr);
        check("inst_valid_in_req", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < rdly; i++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            check("req_valid_stall", {31'd0, imem_req_valid}, 32'd1);
            check("req_addr_stall", imem_req_addr, addr);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("req_valid_wait", {31'd0, imem_req_valid}, 32'd0);
        check("inst_valid_wait", {31'd0, inst_valid}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        imem_resp_err   = err;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        hold(addr, e_inst, e_fault, hdly);
    endtask

    // One-cycle next-PC pulse from the commit stage.
    task automatic commit(input logic [31:0] v);
        npc_valid = 1'b1;
        npc       = v;
        @(negedge clk);
        npc_valid = 1'b0;
    endtask

    // Main directed sequence.
    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        inst_ready      = 1'b0;
        npc_valid       = 1'b0;
        npc             = 32'h0;

        vecs[0] = '{32'h8000_0004, 32'h0020_0113, 1'b0, 32'h0020_0113, 2'd0, 0, 0};
        vecs[1] = '{32'h8000_0008, 32'hDEAD_BEEF, 1'b1, 32'h0000_0013, 2'd1, 1, 1};
        vecs[2] = '{32'h8000_0006, 32'h0000_0000, 1'b0, 32'h0000_0013, 2'd2, 0, 2};
        vecs[3] = '{32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 32'h1234_5678, 2'd0, 2, 0};
        vecs[4] = '{32'h0000_0000, 32'h0000_006F, 1'b0, 32'h0000_006F, 2'd0, 0, 0};
        vecs[5] = '{32'h8000_0001, 32'h0000_0000, 1'b0, 32'h0000_0013, 2'd2, 0, 0};
        vecs[6] = '{32'h8000_000C, 32'hA5A5_5A5A, 1'b1, 32'h0000_0013, 2'd1, 0, 0};

        // Reset cycle: all valids low, holding registers cleared.
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_fault", {30'd0, inst_fault}, 32'd0);
        check("rst_pc", imem_req_addr, 32'h8000_0000);
        rst = 1'b0;

        // First fetch with request and decoder backpressure.
        fetch(32'h8000_0000, 3, 32'h0010_0093, 1'b0, 4, 32'h0010_0093, 2'd0);

        // Idle without npc_valid: no request, nothing presented.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("idle_inst_valid", {31'd0, inst_valid}, 32'd0);
        end

        // Spurious response while waiting for commit is ignored.
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCAFE_F00D;
        imem_resp_err   = 1'b1;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        check("spur_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("spur_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("spur_inst", inst, 32'h0010_0093);
        check("spur_fault", {30'd0, inst_fault}, 32'd0);

        // Table of commit-driven fetches.
        for (int k = 0; k < 7; k++) begin
            commit(vecs[k].npc);
            if (vecs[k].npc[1:0] != 2'b00) begin
                hold(vecs[k].npc, vecs[k].exp_inst, vecs[k].exp_fault, vecs[k].hold_dly);
            end else begin
                fetch(vecs[k].npc, vecs[k].ready_dly, vecs[k].data, vecs[k].err,
                      vecs[k].hold_dly, vecs[k].exp_inst, vecs[k].exp_fault);
            end
        end

        // Reset while an instruction is being presented to the decoder.
        commit(32'h8000_0010);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        check("mid_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("mid_inst", inst, 32'h1111_1111);
        rst = 1'b1;
        #1;
        check("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("post_rst_inst", inst, 32'h0);
        check("post_rst_fault", {30'd0, inst_fault}, 32'd0);
        fetch(32'h8000_0000, 0, 32'h0010_0093, 1'b0, 0, 32'h0010_0093, 2'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ysyx_24070016_ifu_fetch.md
Name: ysyx_24070016_ifu_fetch

Overview:
- Multi-cycle instruction fetch stage; replaces the combinational PC-to-instruction path with a handshaked fetch.
- Owns the architectural PC, issues one word read to instruction memory, and presents the instruction to the decoder with valid/ready.
- Waits for the next PC from the writeback/commit stage before starting the next fetch.
- Exactly one instruction is in flight; no prefetch and no speculation.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- NOP_INST, 32'h00000013, instruction word driven when a fetch faults.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address; equals the PC
- imem_resp_valid  in  1  read data valid; one-cycle pulse
- imem_resp_data  in  32  read data
- imem_resp_err  in  1  access fault, qualified by imem_resp_valid
- inst_valid  out  1  instruction available to the decoder
- inst_ready  in  1  decoder accepts the instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of the instruction
- inst_fault  out  2  fault cause: 0 none, 1 access fault, 2 misaligned PC
- npc_valid  in  1  commit stage supplies the next PC; single-cycle pulse
- npc  in  32  next PC

Behaviour:
- Reset (synchronous, active-high, takes priority over every event):
  - state=S_REQ, pc=RESET_PC, inst=0, inst_fault=0.
  - All valid outputs are 0 in the reset cycle.
  - The memory is reset by the same rst, so no stale response can arrive after reset.
- State S_REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - addr is held stable until acceptance (valid && ready).
  - On acceptance go to S_WAIT.
- State S_WAIT:
  - Capture data and err on imem_resp_valid, then go to S_HOLD.
  - err=1 gives inst=NOP_INST and inst_fault=1; otherwise inst=data and inst_fault=0.
  - A response may arrive no earlier than the cycle after acceptance.
  - resp_valid in any other state is ignored.
- State S_HOLD:
  - inst_valid=1; inst, inst_pc and inst_fault are registered and held stable.
  - On inst_valid && inst_ready go to S_EXEC.
- State S_EXEC:
  - All valid outputs are 0; wait for npc_valid, which is ignored in other states.
  - On npc_valid, load pc<=npc.
  - If npc[1:0]==0: go to S_REQ.
  - Otherwise skip the memory access and go directly to S_HOLD with inst=NOP_INST, inst_fault=2, inst_pc=npc.
- Minimum latency:
  - Request-to-instruction: with req_ready=1 and a response on the next cycle, inst_valid rises 2 cycles after entering S_REQ.
  - npc-to-request: imem_req_valid asserts on the cycle after npc_valid.
- Outputs are fully registered or state-decoded. There is no combinational path from inst_ready or npc_valid to any output.
- No wrap-around special case: npc=32'hFFFFFFFC is fetched normally.
- Protocol assertions (bench only):
  - imem_req_addr is stable while imem_req_valid && !imem_req_ready.
  - inst and inst_pc are stable while inst_valid && !inst_ready.

Decomposition:
- Shared package ysyx_24070016_pkg holds:
  - the state encoding (S_REQ, S_WAIT, S_HOLD, S_EXEC, 2 bits);
  - the fault-cause constants (FAULT_NONE=0, FAULT_ACCESS=1, FAULT_MISALIGN=2);
  - the NOP constant.
- The PC and the instruction holding registers reuse the existing ysyx_24070016_Reg (width, reset value, wen) as the single sub-module.
- The FSM stays in this module.

Test Plan:
- Reset then always-ready memory returning 32'h00100093:
  - imem_req_addr=80000000 in the first post-reset cycle.
  - inst=00100093, inst_pc=80000000, inst_fault=0 on inst_valid.
- Backpressure:
  - req_ready low 3 cycles → addr held at 80000000 throughout.
  - inst_ready low 4 cycles → inst_valid and data held, no second request.
- Commit flow:
  - After acceptance, npc_valid with npc=80000004 → imem_req_addr=80000004 the next cycle.
  - Absent npc_valid the block idles indefinitely with no request.
- Access fault: resp_err=1 with data=DEADBEEF → inst=00000013, inst_fault=1, inst_pc=request address.
- Misaligned PC: npc=80000006 → no imem request, inst_valid next cycle with inst_fault=2, inst_pc=80000006.
- Reset mid-operation:
  - rst asserted in S_HOLD → next cycle inst_valid=0, req_valid=1, addr=80000000.
  - A spurious resp_valid in S_EXEC has no effect.
